// File: rtl/serial_subtractor_4b.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, behind a start/busy/done handshake.
// Latency: start accepted at edge N -> busy for WIDTH cycles -> done pulses for one cycle after edge N+WIDTH.
// Backpressure: start is only accepted in IDLE or DONE; a start while busy is dropped, never queued.
module serial_subtractor_4b #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             a_msb;
   logic             b_msb;

   logic             ai;
   logic             bi;
   logic             d;
   logic             br_nx;
   logic [WIDTH-1:0] res_nx;

   // Single subtract slice on the current LSBs; the new difference bit enters at the MSB side.
   assign ai     = a_sh[0];
   assign bi     = b_sh[0];
   assign d      = ai ^ bi ^ br;
   assign br_nx  = (~ai & bi) | (~(ai ^ bi) & br);
   assign res_nx = {d, res_sh[WIDTH-1:1]};

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; DONE accepts a new start so operations can run back-to-back.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture on accept, then one bit consumed per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         br     <= bin;
         cnt    <= '0;
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
      end else if (state == SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         br     <= br_nx;
         res_sh <= res_nx;
         cnt    <= cnt + CW'(1);
      end
   end

   // Visible results change only on the last bit so no partial value is ever exposed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff <= '0;
         bout <= 1'b0;
         zero <= 1'b0;
         ovf  <= 1'b0;
      end else if (last) begin
         diff <= res_nx;
         bout <= br_nx;
         zero <= (res_nx == '0);
         ovf  <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
      end
   end

endmodule

// File: tb/tb_serial_subtractor_4b.sv
// Self-checking bench for serial_subtractor_4b: directed WIDTH=4 vectors and corner sequences,
// plus a WIDTH=8 randomized regression against an arithmetic reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_serial_subtractor_4b;

   logic       clk;
   logic       rst;

   logic       start4, bin4, busy4, done4, bout4, zero4, ovf4;
   logic [3:0] a4, b4, diff4;
   logic       start8, bin8, busy8, done8, bout8, zero8, ovf8;
   logic [7:0] a8, b8, diff8;

   int checks   = 0;
   int failures = 0;

   serial_subtractor_4b #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
   );

   serial_subtractor_4b #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] diff;
      logic       bout;
      logic       zero;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issue one WIDTH=4 operation from the current cycle and wait (bounded) for done.
   // lat counts edges after the accepting edge until done is seen; nbusy counts busy cycles.
   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output int lat, output int nbusy, output int nboth);
      a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = ~a; b4 = 4'($urandom); bin4 = ~bin;
      lat = 0; nbusy = 0; nboth = 0;
      while (done4 !== 1'b1 && lat < 40) begin
         if (busy4 === 1'b1) nbusy++;
         if (busy4 === 1'b1 && done4 === 1'b1) nboth++;
         tick();
         lat++;
      end
      if (busy4 === 1'b1 && done4 === 1'b1) nboth++;
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int nboth);
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      lat = 0; nboth = 0;
      while (done8 !== 1'b1 && lat < 60) begin
         if (busy8 === 1'b1 && done8 === 1'b1) nboth++;
         tick();
         lat++;
      end
      if (busy8 === 1'b1 && done8 === 1'b1) nboth++;
   endtask

   initial begin
      int lat, nbusy, nboth, ndone;
      logic [7:0] ra, rb, ed;
      logic       rbin, eb, ez, eo;
      int         ediff;

      // a, b, bin -> diff, bout, zero, ovf (ovf from latched MSBs of a, b and the final diff MSB)
      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b0, 1'b1};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b0, 1'b1};
      vecs[2] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vecs[3] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0, 1'b0};
      vecs[4] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b0, 1'b1};
      vecs[5] = '{4'd12, 4'd4,  1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
      vecs[6] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
      vecs[7] = '{4'd7,  4'd8,  1'b0, 4'hF,  1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy4", busy4, 0);
      chk("rst_done4", done4, 0);
      chk("rst_outs4", {diff4, bout4, zero4, ovf4}, 0);
      chk("rst_outs8", {busy8, done8, diff8, bout8, zero8, ovf8}, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy4", busy4, 0);

      // Directed vector table
      foreach (vecs[i]) begin
         run4(vecs[i].a, vecs[i].b, vecs[i].bin, lat, nbusy, nboth);
         chk($sformatf("v%0d_lat", i), lat, 4);
         chk($sformatf("v%0d_busy_cycles", i), nbusy, 4);
         chk($sformatf("v%0d_busy_done_excl", i), nboth, 0);
         chk($sformatf("v%0d_diff", i), diff4, vecs[i].diff);
         chk($sformatf("v%0d_bout", i), bout4, vecs[i].bout);
         chk($sformatf("v%0d_zero", i), zero4, vecs[i].zero);
         chk($sformatf("v%0d_ovf", i), ovf4, vecs[i].ovf);
         tick();
         chk($sformatf("v%0d_done_pulse", i), done4, 0);
      end

      // Results hold in IDLE
      repeat (3) tick();
      chk("hold_diff", diff4, 4'hF);
      chk("hold_flags", {bout4, zero4, ovf4}, 3'b101);

      // start re-pulsed while busy is ignored
      a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
      tick();
      a4 = 4'd15; b4 = 4'd0;
      ndone = 0;
      repeat (3) begin
         tick();
         if (done4 === 1'b1) ndone++;
      end
      start4 = 1'b0;
      chk("ign_still_busy", busy4, 1);
      tick();
      chk("ign_done", done4, 1);
      chk("ign_early_done", ndone, 0);
      chk("ign_diff", diff4, 4'd6);
      // back-to-back: start held in the DONE cycle
      a4 = 4'd12; b4 = 4'd4; start4 = 1'b1;
      tick();
      start4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
      chk("b2b_accepted", busy4, 1);
      lat = 0;
      while (done4 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("b2b_lat", lat, 4);
      chk("b2b_diff", diff4, 4'd8);
      tick();
      ndone = 0;
      repeat (4) begin
         tick();
         if (done4 === 1'b1) ndone++;
      end
      chk("b2b_single_done", ndone, 0);

      // Asynchronous reset mid-SHIFT
      a4 = 4'd3; b4 = 4'd9; bin4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy4, 0);
      chk("arst_outs", {done4, diff4, bout4, zero4, ovf4}, 0);
      #3 rst = 1'b0;
      ndone = 0;
      repeat (6) begin
         tick();
         if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
      end
      chk("arst_no_done", ndone, 0);
      run4(4'd12, 4'd4, 1'b0, lat, nbusy, nboth);
      chk("arst_after_lat", lat, 4);
      chk("arst_after_diff", diff4, 4'd8);
      tick();

      // WIDTH=8 randomized regression
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         if (n < 4) begin
            ra = (n[0]) ? 8'h00 : 8'h80;
            rb = (n[1]) ? 8'hFF : 8'h01;
         end
         ediff = int'(ra) - int'(rb) - int'(rbin);
         eb    = (ediff < 0);
         ed    = 8'(ediff);
         ez    = (ed == 8'd0);
         eo    = (ra[7] != rb[7]) && (ed[7] != ra[7]);
         run8(ra, rb, rbin, lat, nboth);
         chk($sformatf("r%0d_lat", n), lat, 8);
         chk($sformatf("r%0d_diff", n), diff8, ed);
         chk($sformatf("r%0d_bout", n), bout8, eb);
         chk($sformatf("r%0d_zero", n), zero8, ez);
         chk($sformatf("r%0d_ovf", n), ovf8, eo);
         chk($sformatf("r%0d_excl", n), nboth, 0);
         // gap 0 means the next start lands in the DONE cycle
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
